cl_wr_packer: RTL and testbench

- Host-bound counterpart of the host-to-memory unpacking path.
- Reads 32-bit words from the local memory controller's DMA port, packs 16 consecutive words into one 512-bit cache line, and pushes each line into the DMA write channel.
- Sits in the AFU between memory_controller (DMA port) and dma.wr_en / dma.wr_data.
- Started by the end-of-read/compute indication; writes exactly num_lines cache lines.

---
 rtl/cl_wr_packer.sv | 117 +++++++++++
 tb/tb_cl_wr_packer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_wr_packer.sv
// Packs WPL consecutive memory words into one cache line and pushes each line
// to the DMA write channel; writes exactly num_lines lines per start.
//
// state  | meaning
// IDLE   | waiting for start after reset
// REQ    | issuing one memory read (mem_en pulse)
// WAIT   | waiting for mem_valid, capturing word k
// PUSH   | line complete, writing it when the DMA FIFO has room
// DONE   | transfer finished, done held, new start accepted
module cl_wr_packer #(
    parameter int CL_WIDTH   = 512,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 28,
    parameter int SIZE_WIDTH = 43
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SIZE_WIDTH-1:0] num_lines,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WORD_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_valid,
    input  logic                  wr_full,
    output logic                  wr_en,
    output logic [CL_WIDTH-1:0]   wr_data,
    output logic                  busy,
    output logic                  done
);

    localparam int WPL = CL_WIDTH / WORD_WIDTH;
    localparam int KW  = (WPL > 1) ? $clog2(WPL) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_PUSH = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]            state;
    logic [KW-1:0]         word_cnt;
    logic [SIZE_WIDTH-1:0] line_cnt;
    logic [SIZE_WIDTH-1:0] num_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CL_WIDTH-1:0]   line_buf;
    logic [CL_WIDTH-1:0]   line_next;
    logic [CL_WIDTH-1:0]   wr_data_q;
    logic                  last_word;
    logic                  push;

    always_comb begin
        line_next = line_buf;
        line_next[word_cnt*WORD_WIDTH +: WORD_WIDTH] = mem_rd_data;
    end

    assign last_word = (word_cnt == KW'(WPL - 1));
    assign push      = (state == S_PUSH) && !wr_full;

    assign mem_en   = (state == S_REQ);
    assign mem_addr = addr_q;
    assign wr_en    = push;
    assign wr_data  = wr_data_q;
    assign busy     = (state == S_REQ) || (state == S_WAIT) || (state == S_PUSH);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            word_cnt  <= '0;
            line_cnt  <= '0;
            num_q     <= '0;
            addr_q    <= '0;
            line_buf  <= '0;
            wr_data_q <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        num_q    <= num_lines;
                        addr_q   <= base_addr;
                        word_cnt <= '0;
                        line_cnt <= '0;
                        state    <= (num_lines == '0) ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    // addr_q always points at the next word to request; wraps silently
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_valid) begin
                        line_buf <= line_next;
                        word_cnt <= word_cnt + KW'(1);
                        if (last_word) begin
                            // separate output register keeps wr_data stable while the next line fills
                            wr_data_q <= line_next;
                            state     <= S_PUSH;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                S_PUSH: begin
                    if (!wr_full) begin
                        line_cnt <= line_cnt + SIZE_WIDTH'(1);
                        word_cnt <= '0;
                        state    <= (line_cnt + SIZE_WIDTH'(1) == num_q) ? S_DONE : S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cl_wr_packer.sv
// Randomized scoreboard bench for cl_wr_packer: a memory responder returns
// addr^salt, expected addresses and lines are queued when a transfer is issued.
module tb_cl_wr_packer;

    localparam int CLW = 512;
    localparam int WW  = 32;
    localparam int AW  = 28;
    localparam int SW  = 43;
    localparam int WPL = CLW / WW;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [SW-1:0]  num_lines;
    logic [AW-1:0]  base_addr;
    logic           mem_en;
    logic [AW-1:0]  mem_addr;
    logic [WW-1:0]  mem_rd_data;
    logic           mem_valid;
    logic           wr_full;
    logic           wr_en;
    logic [CLW-1:0] wr_data;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    cl_wr_packer #(
        .CL_WIDTH(CLW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_lines(num_lines),
        .base_addr(base_addr), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .mem_valid(mem_valid), .wr_full(wr_full),
        .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .done(done)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [AW-1:0]  exp_addr[$];
    logic [CLW-1:0] exp_line[$];
    int             wr_cycs[$];
    int             mem_cnt = 0;
    int             wr_cnt  = 0;
    int             mv_cnt  = 0;
    bit             outstanding = 1'b0;
    int             mem_lat = 1;
    logic [WW-1:0]  mem_salt = '0;
    int             bp_mode = 0;
    logic [AW-1:0]  req_addr;
    event           req_ev;

    function automatic logic [WW-1:0] mem_word(logic [AW-1:0] a, logic [WW-1:0] salt);
        return {{(WW-AW){1'b0}}, a} ^ salt;
    endfunction

    function automatic logic [CLW-1:0] model_line(logic [AW-1:0] base, int l, logic [WW-1:0] salt);
        logic [CLW-1:0] v;
        logic [AW-1:0]  a;
        v = '0;
        for (int k = 0; k < WPL; k++) begin
            a = base + AW'(l * WPL + k);
            v[k*WW +: WW] = mem_word(a, salt);
        end
        return v;
    endfunction

    task automatic chk(string name, logic [CLW-1:0] act, logic [CLW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(logic [AW-1:0] b, int n);
        for (int l = 0; l < n; l++) exp_line.push_back(model_line(b, l, mem_salt));
        for (int i = 0; i < n * WPL; i++) exp_addr.push_back(b + AW'(i));
    endtask

    task automatic drive_start(logic [AW-1:0] b, logic [SW-1:0] n, output int s);
        @(posedge clk); #2;
        start = 1'b1; base_addr = b; num_lines = n; s = cyc;
        @(posedge clk); #2;
        start = 1'b0; base_addr = AW'($urandom); num_lines = SW'($urandom_range(50, 99));
    endtask

    task automatic transfer(logic [AW-1:0] b, int n, logic [WW-1:0] salt, output int s);
        mem_salt = salt;
        issue(b, n);
        drive_start(b, SW'(n), s);
    endtask

    task automatic wait_done(output int dc);
        bit seen;
        seen = 1'b0;
        dc = -1;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; dc = cyc; end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL wait_done: done never rose within bound (cycle %0d)", cyc);
        end
    endtask

    task automatic clear_stats();
        mem_cnt = 0; wr_cnt = 0; mv_cnt = 0; wr_cycs.delete();
    endtask

    task automatic end_checks();
        chk("addr_queue_drained", exp_addr.size(), 0);
        chk("line_queue_drained", exp_line.size(), 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (rst === 1'b0) begin
            if (mem_en) begin
                mem_cnt++;
                chk("single_outstanding", outstanding, 0);
                if (exp_addr.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_mem_en: addr %0h with nothing expected", mem_addr);
                end else begin
                    chk("mem_addr", mem_addr, exp_addr.pop_front());
                end
                outstanding = 1'b1;
                req_addr = mem_addr;
                -> req_ev;
            end
            if (wr_en) begin
                wr_cnt++;
                wr_cycs.push_back(cyc);
                chk("wr_en_while_full", wr_full, 0);
                if (exp_line.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_wr_en: line %0h with nothing expected", wr_data);
                end else begin
                    chk("wr_data", wr_data, exp_line.pop_front());
                end
            end
        end
    end

    // memory responder
    initial begin
        logic [AW-1:0] a;
        mem_valid = 1'b0;
        mem_rd_data = '0;
        forever begin
            @(req_ev);
            a = req_addr;
            repeat (mem_lat) @(posedge clk);
            #2;
            mem_valid = 1'b1;
            mem_rd_data = mem_word(a, mem_salt);
            outstanding = 1'b0;
            mv_cnt++;
            @(posedge clk); #2;
            mem_valid = 1'b0;
            mem_rd_data = $urandom;
        end
    end

    initial forever begin
        @(posedge clk); #2;
        if (bp_mode == 1) wr_full = ($urandom_range(0, 2) == 0);
    end

    initial begin
        int s, dc, n;
        logic [AW-1:0]  b;
        logic [CLW-1:0] line0;

        rst = 1'b1; start = 1'b0; num_lines = '0; base_addr = '0; wr_full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #2;
        rst = 1'b0;

        // single line, data = address
        clear_stats(); mem_lat = 1;
        transfer(28'h100, 1, '0, s);
        wait_done(dc);
        chk("single_wr_count", wr_cnt, 1);
        chk("single_mem_count", mem_cnt, 16);
        if (wr_cycs.size() > 0) begin
            chk("single_first_wr_latency", wr_cycs[0] - s, 33);
            chk("single_done_after_push", dc - wr_cycs[0], 1);
        end
        end_checks();

        // backpressure on the first line
        clear_stats();
        wr_full = 1'b1;
        line0 = model_line(28'h100, 0, 32'h5a5a0000);
        transfer(28'h100, 2, 32'h5a5a0000, s);
        while (cyc < s + 33) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_wr_en_held_low", wr_en, 0);
            chk("bp_wr_data_stable", wr_data, line0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #2;
        wr_full = 1'b0;
        wait_done(dc);
        chk("bp_wr_count", wr_cnt, 2);
        if (wr_cycs.size() > 0) chk("bp_push_after_release", wr_cycs[0] - s, 38);
        end_checks();

        // start while busy is ignored, then a fresh start clears done
        clear_stats(); mem_lat = 2;
        b = AW'($urandom);
        transfer(b, 2, $urandom, s);
        repeat (40) @(posedge clk);
        #2;
        start = 1'b1; base_addr = AW'($urandom); num_lines = 7;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(dc);
        chk("busy_start_wr_count", wr_cnt, 2);
        chk("busy_start_mem_count", mem_cnt, 32);
        end_checks();
        clear_stats();
        transfer(AW'($urandom), 1, $urandom, s);
        @(negedge clk);
        chk("restart_done_cleared", done, 0);
        chk("restart_busy", busy, 1);
        wait_done(dc);
        end_checks();

        // reset mid-transfer with a late response
        clear_stats(); mem_lat = 3;
        transfer(AW'($urandom), 1, $urandom, s);
        for (int i = 0; i < 2000 && mem_cnt < 9; i++) begin
            @(negedge clk); #1;
        end
        chk("abort_reached_word8", mem_cnt, 9);
        @(posedge clk); #2;
        rst = 1'b1;
        exp_addr.delete(); exp_line.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_mem_en", mem_en, 0);
            chk("abort_mem_addr", mem_addr, 0);
            chk("abort_wr_en", wr_en, 0);
            chk("abort_wr_data", wr_data, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
        end
        chk("abort_late_valid_seen", mv_cnt, 9);

        // zero length from IDLE
        clear_stats();
        drive_start(28'h55, '0, s);
        @(negedge clk);
        chk("zero_done_next_cycle", done, 1);
        chk("zero_busy", busy, 0);
        repeat (5) @(negedge clk);
        chk("zero_mem_count", mem_cnt, 0);
        chk("zero_wr_count", wr_cnt, 0);

        // address wrap with 3-cycle latency
        clear_stats(); mem_lat = 3;
        transfer(28'hFFFFFF8, 1, $urandom, s);
        wait_done(dc);
        chk("wrap_mem_count", mem_cnt, 16);
        chk("wrap_wr_count", wr_cnt, 1);
        end_checks();

        // randomized transfers with random latency and backpressure
        bp_mode = 1;
        for (int t = 0; t < 6; t++) begin
            clear_stats();
            mem_lat = $urandom_range(1, 4);
            n = $urandom_range(1, 3);
            transfer(AW'($urandom), n, $urandom, s);
            wait_done(dc);
            chk("rand_wr_count", wr_cnt, n);
            chk("rand_mem_count", mem_cnt, n * WPL);
            end_checks();
        end
        bp_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
